// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - rebuilds VGA column/row counters and lock status from raw HSYNC/VSYNC
module vga_sync_receiver #(
  parameter int H_VISIBLE    = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int H_TOTAL      = 800,
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492,
  parameter int V_TOTAL      = 525,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] curr_col,
  output logic [9:0] curr_row,
  output logic       valid,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err
);

  localparam int WD_W = $clog2(2 * H_TOTAL) + 1;
  localparam logic [9:0] HVIS   = 10'(H_VISIBLE);
  localparam logic [9:0] HSS    = 10'(H_SYNC_START);
  localparam logic [9:0] HSE    = 10'(H_SYNC_END);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] VVIS   = 10'(V_VISIBLE);
  localparam logic [9:0] VSS    = 10'(V_SYNC_START);
  localparam logic [9:0] VSE    = 10'(V_SYNC_END);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(2 * H_TOTAL - 1);
  localparam logic [3:0] GOOD_LAST = 4'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCK} state_t;

  state_t          state;
  logic [2:0]      hs;
  logic [2:0]      vs;
  logic [3:0]      good_cnt;
  logic            frame_bad;
  logic [WD_W-1:0] wd_cnt;

  logic       h_fall, h_rise, v_fall, v_rise;
  logic       wd_expire, mismatch;
  logic [9:0] col_next, row_next;

  // hs[1]/vs[1] are the synchronized samples, hs[2]/vs[2] the previous ones
  assign h_fall = !hs[1] && hs[2];
  assign h_rise = hs[1] && !hs[2];
  assign v_fall = !vs[1] && vs[2];
  assign v_rise = vs[1] && !vs[2];

  assign wd_expire = (wd_cnt == WD_LAST) && !h_fall;

  assign mismatch = (h_fall && curr_col != HSS) ||
                    (h_rise && curr_col != HSE) ||
                    (v_fall && (curr_row != VSS || curr_col != 10'd0)) ||
                    (v_rise && (curr_row != VSE || curr_col != 10'd0)) ||
                    wd_expire;

  // An h_fall reload never produces a row wrap; v_fall pins the row only
  always_comb begin
    col_next = (curr_col == H_LAST) ? 10'd0 : curr_col + 10'd1;
    row_next = curr_row;
    if (curr_col == H_LAST)
      row_next = (curr_row == V_LAST) ? 10'd0 : curr_row + 10'd1;
    if (h_fall) begin
      col_next = HSS + 10'd1;
      row_next = curr_row;
    end
    if (v_fall)
      row_next = VSS;
  end

  assign valid       = locked && (curr_col < HVIS) && (curr_row < VVIS);
  assign frame_start = locked && (curr_col == 10'd0) && (curr_row == 10'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs        <= 3'b111;
      vs        <= 3'b111;
      curr_col  <= 10'd0;
      curr_row  <= 10'd0;
      wd_cnt    <= '0;
      state     <= SEARCH;
      good_cnt  <= 4'd0;
      frame_bad <= 1'b0;
      locked    <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      hs       <= {hs[1:0], hsync_in};
      vs       <= {vs[1:0], vsync_in};
      curr_col <= col_next;
      curr_row <= row_next;
      wd_cnt   <= (h_fall || wd_expire) ? '0 : wd_cnt + 1'b1;
      sync_err <= 1'b0;
      case (state)
        SEARCH: begin
          if (v_fall) begin
            state     <= ALIGN;
            good_cnt  <= 4'd0;
            frame_bad <= 1'b0;
          end
        end
        ALIGN: begin
          // The closing v_fall is itself checked before the frame counts as clean
          if (v_fall) begin
            frame_bad <= 1'b0;
            if (!frame_bad && !mismatch) begin
              good_cnt <= good_cnt + 4'd1;
              if (good_cnt == GOOD_LAST) begin
                state  <= LOCK;
                locked <= 1'b1;
              end
            end else begin
              good_cnt <= 4'd0;
            end
          end else if (mismatch) begin
            frame_bad <= 1'b1;
          end
        end
        LOCK: begin
          if (mismatch) begin
            sync_err <= 1'b1;
            locked   <= 1'b0;
            state    <= SEARCH;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - directed bench for vga_sync_receiver on a scaled 32x16 timing
module tb_vga_sync_receiver;

  localparam int HV = 16, HSS = 20, HSE = 26, HT = 32;
  localparam int VV = 10, VSS = 12, VSE = 14, VT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic [9:0] curr_col, curr_row;
  logic       valid, locked, frame_start, sync_err;

  vga_sync_receiver #(
    .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .curr_col(curr_col), .curr_row(curr_row), .valid(valid), .locked(locked),
    .frame_start(frame_start), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int gen_col = 0, gen_row = 0, prev_col = 0, prev_row = 0;
  bit short_once = 0, wide_once = 0, hold = 0, trk_en = 0, lk_en = 0;
  int vf_cnt = 0, serr_cnt = 0, valid_cnt = 0, fs_cnt = 0;
  int trk_err = 0, vld_err = 0, lk_drop = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: observe just after the edge, then advance the reference generator
  task automatic step();
    int   last;
    logic hs_n, vs_n;
    @(posedge clk);
    #1;
    if (sync_err === 1'b1) serr_cnt++;
    if (valid === 1'b1) valid_cnt++;
    if (frame_start === 1'b1) fs_cnt++;
    if (trk_en && (curr_col !== 10'(prev_col) || curr_row !== 10'(prev_row))) trk_err++;
    if (lk_en && valid !== (prev_col < HV && prev_row < VV)) vld_err++;
    if (lk_en && locked !== 1'b1) lk_drop++;
    prev_col = gen_col;
    prev_row = gen_row;
    last = short_once ? HT - 2 : HT - 1;
    if (gen_col >= last) begin
      gen_col    = 0;
      short_once = 0;
      wide_once  = 0;
      gen_row    = (gen_row == VT - 1) ? 0 : gen_row + 1;
    end else begin
      gen_col++;
    end
    hs_n = hold || !(gen_col >= HSS && gen_col < (wide_once ? HSE + 1 : HSE));
    vs_n = !(gen_row >= VSS && gen_row < VSE);
    if (vsync_in && !vs_n) vf_cnt++;
    hsync_in = hs_n;
    vsync_in = vs_n;
  endtask

  task automatic run_vf(input int n);
    int target = vf_cnt + n;
    int k = 0;
    while (vf_cnt < target && k < 4 * HT * VT) begin
      step();
      k++;
    end
  endtask

  task automatic wait_line(input int row);
    int k = 0;
    do begin
      step();
      k++;
    end while (!(gen_col == 0 && gen_row == row) && k < 2 * HT * VT);
  endtask

  // Called right after the step that drove a v_fall expected to complete lock
  task automatic lock_edge(input string tag, input logic exp_lock);
    step();
    step();
    check({tag, "_pre"}, 32'(locked), 0);
    step();
    check({tag, "_post"}, 32'(locked), 32'(exp_lock));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    check("rst_col", 32'(curr_col), 0);
    check("rst_row", 32'(curr_row), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_fs", 32'(frame_start), 0);
    check("rst_serr", 32'(sync_err), 0);
    rst = 1'b0;

    run_vf(3);
    lock_edge("lock1", 1'b1);

    serr_cnt = 0; valid_cnt = 0; fs_cnt = 0; trk_err = 0; vld_err = 0; lk_drop = 0;
    trk_en = 1; lk_en = 1;
    repeat (HT * VT) step();
    trk_en = 0; lk_en = 0;
    check("trk_err", 32'(trk_err), 0);
    check("valid_err", 32'(vld_err), 0);
    check("valid_cnt", 32'(valid_cnt), HV * VV);
    check("fs_cnt", 32'(fs_cnt), 1);
    check("trk_serr", 32'(serr_cnt), 0);
    check("trk_lkdrop", 32'(lk_drop), 0);

    wait_line(3);
    serr_cnt = 0;
    short_once = 1;
    k = 0;
    while (serr_cnt == 0 && k < 3 * HT) begin
      step();
      k++;
    end
    check("short_serr", 32'(serr_cnt), 1);
    check("short_unlock", 32'(locked), 0);
    run_vf(3);
    lock_edge("relock_short", 1'b1);
    check("short_one_pulse", 32'(serr_cnt), 1);

    wait_line(5);
    repeat (5) step();
    check("prerst_locked", 32'(locked), 1);
    check("prerst_valid", 32'(valid), 1);
    rst = 1'b1;
    #1;
    check("arst_col", 32'(curr_col), 0);
    check("arst_row", 32'(curr_row), 0);
    check("arst_locked", 32'(locked), 0);
    check("arst_valid", 32'(valid), 0);
    repeat (3) step();
    rst = 1'b0;
    run_vf(3);
    lock_edge("relock_rst", 1'b1);

    wait_line(1);
    serr_cnt = 0; trk_err = 0;
    hold = 1; trk_en = 1;
    repeat (80) step();
    hold = 0; trk_en = 0;
    check("wd_serr", 32'(serr_cnt), 1);
    check("wd_unlock", 32'(locked), 0);
    check("wd_freerun", 32'(trk_err), 0);

    wait_line(2);
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    serr_cnt = 0;
    run_vf(1);
    wide_once = 1;
    run_vf(2);
    repeat (3) step();
    check("wide_delayed", 32'(locked), 0);
    run_vf(1);
    lock_edge("wide_lock", 1'b1);
    check("wide_no_serr", 32'(serr_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
